// File: rtl/collision_sched_if.sv
// Handshake/bus bundle between the collision sequencer and its tracker/collision-unit neighbours.
// master = stimulus side (tracker + collision unit), slave = collision_sched.
interface collision_sched_if;
  logic       frame;
  logic [3:0] hit;
  logic [7:0] hit_phi;
  logic [2:0] impact_in;
  logic       update;
  logic       rotate;
  logic       mirror;
  logic [1:0] phi;
  logic       round_dir;
  logic       busy;
  logic [1:0] last_wall;
  logic [2:0] peak_impact;
  logic       overflow;

  modport master (
    output frame, hit, hit_phi, impact_in,
    input  update, rotate, mirror, phi, round_dir, busy, last_wall, peak_impact, overflow
  );

  modport slave (
    input  frame, hit, hit_phi, impact_in,
    output update, rotate, mirror, phi, round_dir, busy, last_wall, peak_impact, overflow
  );
endinterface

// File: rtl/collision_sched.sv
// Round-robin wall-hit sequencer: latch hits, grant one wall per 4-cycle IDLE/SETUP/FIRE/SETTLE pass.
// Optional ROUND_LFSR_EN: round_dir from an 8-bit LFSR instead of a toggle flop.
module collision_sched (
  input  logic              clk,
  input  logic              rst,
  collision_sched_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SETUP, FIRE, SETTLE} state_t;

  state_t     state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [3:0] done_q, done_d;
  logic [7:0] phi_st_q, phi_st_d;
  logic [1:0] ptr_q, ptr_d;
  logic       rotate_q, rotate_d;
  logic       mirror_q, mirror_d;
  logic [1:0] phi_q, phi_d;
  logic [1:0] last_wall_q, last_wall_d;
  logic [2:0] peak_q, peak_d;
  logic       overflow_q, overflow_d;
`ifdef ROUND_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
`else
  logic       round_q, round_d;
`endif

  logic       grant_vld;
  logic [1:0] grant_idx;

  // Scan downward so the pending wall closest to the pointer wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      if (pending_q[ptr_q + 2'(k)]) begin
        grant_vld = 1'b1;
        grant_idx = ptr_q + 2'(k);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    done_d      = done_q;
    phi_st_d    = phi_st_q;
    ptr_d       = ptr_q;
    rotate_d    = rotate_q;
    mirror_d    = mirror_q;
    phi_d       = phi_q;
    last_wall_d = last_wall_q;
    peak_d      = peak_q;
    overflow_d  = overflow_q;
`ifdef ROUND_LFSR_EN
    lfsr_d      = lfsr_q;
`else
    round_d     = round_q;
`endif

    // Frame clears lockout before hits are judged, so a same-cycle hit is accepted.
    if (bus.frame) begin
      done_d = '0;
      peak_d = '0;
    end

    for (int i = 0; i < 4; i++) begin
      if (bus.hit[i] && !done_d[i]) begin
        if (pending_q[i]) overflow_d = 1'b1;
        pending_d[i]        = 1'b1;
        phi_st_d[2*i +: 2]  = bus.hit_phi[2*i +: 2];
      end
    end

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          rotate_d             = grant_idx[0];
          mirror_d             = grant_idx[0] ^ grant_idx[1];
          phi_d                = phi_st_q[{grant_idx, 1'b0} +: 2];
          pending_d[grant_idx] = 1'b0;
          done_d[grant_idx]    = 1'b1;
          last_wall_d          = grant_idx;
          ptr_d                = grant_idx + 2'd1;
          state_d              = SETUP;
        end
      end
      SETUP: state_d = FIRE;
      FIRE: begin
`ifdef ROUND_LFSR_EN
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`else
        round_d = ~round_q;
`endif
        state_d = SETTLE;
      end
      SETTLE: begin
        if (bus.frame)                   peak_d = bus.impact_in;
        else if (bus.impact_in > peak_q) peak_d = bus.impact_in;
        else                             peak_d = peak_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      done_q      <= '0;
      phi_st_q    <= '0;
      ptr_q       <= '0;
      rotate_q    <= 1'b0;
      mirror_q    <= 1'b0;
      phi_q       <= '0;
      last_wall_q <= '0;
      peak_q      <= '0;
      overflow_q  <= 1'b0;
`ifdef ROUND_LFSR_EN
      lfsr_q      <= 8'h01;
`else
      round_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
      phi_st_q    <= phi_st_d;
      ptr_q       <= ptr_d;
      rotate_q    <= rotate_d;
      mirror_q    <= mirror_d;
      phi_q       <= phi_d;
      last_wall_q <= last_wall_d;
      peak_q      <= peak_d;
      overflow_q  <= overflow_d;
`ifdef ROUND_LFSR_EN
      lfsr_q      <= lfsr_d;
`else
      round_q     <= round_d;
`endif
    end
  end

  // Gate with rst so a reset landing in FIRE cannot leak a strobe.
  assign bus.update      = (state_q == FIRE) && !rst;
  assign bus.busy        = (state_q != IDLE);
  assign bus.rotate      = rotate_q;
  assign bus.mirror      = mirror_q;
  assign bus.phi         = phi_q;
  assign bus.last_wall   = last_wall_q;
  assign bus.peak_impact = peak_q;
  assign bus.overflow    = overflow_q;
`ifdef ROUND_LFSR_EN
  assign bus.round_dir   = lfsr_q[0];
`else
  assign bus.round_dir   = round_q;
`endif
endmodule

// File: tb/tb_collision_sched.sv
// Directed bench for collision_sched: grant scoreboard popped on each update strobe.
module tb_collision_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  collision_sched_if bus();
  collision_sched dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {logic [1:0] wall; logic [1:0] phi;} exp_t;
  exp_t exp_q[$];
  int   upd_cyc[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_upd = 0;
  int   cyc   = 0;
  logic       rd_model;
  logic [7:0] lfsr_model;
  logic [3:0] rot_tbl = 4'b1010;   // top/right/bottom/left
  logic [3:0] mir_tbl = 4'b0110;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
`ifdef ROUND_LFSR_EN
    lfsr_model = 8'h01;
    rd_model   = 1'b1;
`else
    rd_model   = 1'b0;
`endif
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.update) begin
      n_upd++;
      upd_cyc.push_back(cyc);
      chk("update_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("grant_wall", bus.last_wall, e.wall);
        chk("grant_phi", bus.phi, e.phi);
        chk("grant_rotate", bus.rotate, rot_tbl[e.wall]);
        chk("grant_mirror", bus.mirror, mir_tbl[e.wall]);
      end
      chk("round_dir_at_fire", bus.round_dir, rd_model);
`ifdef ROUND_LFSR_EN
      lfsr_model = {lfsr_model[6:0], lfsr_model[7] ^ lfsr_model[5] ^ lfsr_model[4] ^ lfsr_model[3]};
      rd_model   = lfsr_model[0];
`else
      rd_model   = ~rd_model;
`endif
    end
  endtask

  task automatic pulse_hit(input logic [3:0] h, input logic [7:0] p);
    bus.hit     = h;
    bus.hit_phi = p;
    step();
    bus.hit     = '0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && (bus.busy || exp_q.size() != 0); i++) step();
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_update"}, bus.update, 0);
    chk({tag, "_rotate"}, bus.rotate, 0);
    chk({tag, "_mirror"}, bus.mirror, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_overflow"}, bus.overflow, 0);
    chk({tag, "_phi"}, bus.phi, 0);
    chk({tag, "_last_wall"}, bus.last_wall, 0);
    chk({tag, "_peak"}, bus.peak_impact, 0);
    chk({tag, "_round_dir"}, bus.round_dir, rd_model);
  endtask

  initial begin
    int t0, base, u0;
    rst = 1'b1;
    bus.frame = 1'b0; bus.hit = '0; bus.hit_phi = '0; bus.impact_in = '0;
    model_reset();
    repeat (3) step();
    check_reset_outputs("reset");
    rst = 1'b0;
    step();

    // All four walls at once from pointer 0: grants 0..3, one update every 4 cycles.
    t0 = cyc; base = upd_cyc.size();
    for (int w = 0; w < 4; w++) exp_q.push_back('{wall: 2'(w), phi: 2'(w)});
    pulse_hit(4'b1111, 8'hE4);
    drain("simul");
    chk("simul_update_count", upd_cyc.size() - base, 4);
    if (upd_cyc.size() - base == 4)
      for (int k = 0; k < 4; k++) chk("simul_update_cycle", upd_cyc[base + k], t0 + 3 + 4 * k);

    // Single hit on bottom, with frame in the same cycle so the locked-out wall is accepted.
    t0 = cyc; base = upd_cyc.size();
    exp_q.push_back('{wall: 2'd2, phi: 2'd2});
    bus.frame = 1'b1;
    bus.impact_in = 3'd3;
    pulse_hit(4'b0100, 8'h20);
    bus.frame = 1'b0;
    chk("single_t1_update", bus.update, 0);
    step();
    chk("single_setup_rotate", bus.rotate, 0);
    chk("single_setup_mirror", bus.mirror, 1);
    chk("single_setup_phi", bus.phi, 2'b10);
    chk("single_setup_update", bus.update, 0);
    chk("single_setup_busy", bus.busy, 1);
    step();
    chk("single_fire_update", bus.update, 1);
    step();
    chk("single_settle_update", bus.update, 0);
    chk("single_settle_phi", bus.phi, 2'b10);
    chk("single_settle_mirror", bus.mirror, 1);
    step();
    chk("single_last_wall", bus.last_wall, 2);
    chk("single_peak", bus.peak_impact, 3);
    chk("single_update_count", upd_cyc.size() - base, 1);
    if (upd_cyc.size() - base == 1) chk("single_update_cycle", upd_cyc[base], t0 + 3);
    drain("single");

    // Lockout: second top hit without frame is ignored; after frame it is granted again.
    bus.impact_in = 3'd0;
    u0 = n_upd;
    exp_q.push_back('{wall: 2'd0, phi: 2'd1});
    pulse_hit(4'b0001, 8'h01);
    drain("lock_first");
    pulse_hit(4'b0001, 8'h02);
    repeat (8) step();
    chk("lock_one_update", n_upd - u0, 1);
    chk("lock_no_overflow", bus.overflow, 0);
    bus.frame = 1'b1; step(); bus.frame = 1'b0;
    exp_q.push_back('{wall: 2'd0, phi: 2'd2});
    pulse_hit(4'b0001, 8'h02);
    drain("lock_second");
    chk("lock_two_updates", n_upd - u0, 2);

    // Overflow: left wall hit twice while pending behind a right-wall grant; last phi wins.
    exp_q.push_back('{wall: 2'd1, phi: 2'd0});
    pulse_hit(4'b0010, 8'h00);
    step();
    chk("ovf_busy", bus.busy, 1);
    pulse_hit(4'b1000, 8'h40);
    pulse_hit(4'b1000, 8'hC0);
    exp_q.push_back('{wall: 2'd3, phi: 2'd3});
    drain("ovf");
    chk("ovf_flag", bus.overflow, 1);

    // Peak impact: 5 then 2 keeps 5; frame during SETTLE with 1 loads 1.
    bus.frame = 1'b1; step(); bus.frame = 1'b0;
    chk("peak_after_frame", bus.peak_impact, 0);
    bus.impact_in = 3'd5;
    exp_q.push_back('{wall: 2'd0, phi: 2'd0});
    pulse_hit(4'b0001, 8'h00);
    drain("peak5");
    chk("peak_5", bus.peak_impact, 5);
    bus.impact_in = 3'd2;
    exp_q.push_back('{wall: 2'd2, phi: 2'd1});
    pulse_hit(4'b0100, 8'h10);
    drain("peak2");
    chk("peak_keeps_5", bus.peak_impact, 5);
    bus.impact_in = 3'd1;
    exp_q.push_back('{wall: 2'd1, phi: 2'd3});
    pulse_hit(4'b0010, 8'h0C);
    for (int i = 0; i < 10 && !bus.update; i++) step();
    chk("peak_fire_seen", bus.update, 1);
    step();
    bus.frame = 1'b1; step(); bus.frame = 1'b0;
    chk("peak_frame_in_settle", bus.peak_impact, 1);
    drain("peak1");
    bus.impact_in = 3'd0;

    // Reset landing in SETUP: no strobe, everything back to reset values.
    u0 = n_upd;
    pulse_hit(4'b0100, 8'h30);
    step();
    chk("rst_in_setup_busy", bus.busy, 1);
    rst = 1'b1;
    step();
    model_reset();
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (6) step();
    chk("midrst_no_update", n_upd - u0, 0);

    // Four FIREs from reset: round_dir steps through the reference sequence.
    for (int w = 0; w < 4; w++) exp_q.push_back('{wall: 2'(w), phi: 2'(3 - w)});
    pulse_hit(4'b1111, 8'h1B);
    drain("rdir");
    chk("round_dir_final", bus.round_dir, rd_model);
`ifndef ROUND_LFSR_EN
    chk("round_dir_after4", bus.round_dir, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/collision_sched.md
# collision_sched

Sequencer for the capsule collision datapath. It latches wall-hit events from the position tracker and arbitrates among the four walls round-robin. For each granted wall it drives a stable rotate/mirror/phi/round_dir setup and then a single-cycle update strobe into the collision unit. It records the resulting impact magnitude and enforces one bounce per wall per frame.

## Interface
Parameters:
- none

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- frame  in  1  frame-start pulse; clears per-frame lockout and peak impact
- hit  in  4  wall-hit pulses: [0] top, [1] right, [2] bottom, [3] left
- hit_phi  in  8  contact angle, 2 bits per wall, same index order
- impact_in  in  3  impact code returned by the collision unit
- update  out  1  one-cycle strobe to the collision unit
- rotate  out  1  0 for top/bottom, 1 for left/right
- mirror  out  1  0 for top/left, 1 for bottom/right
- phi  out  2  contact angle of the granted wall
- round_dir  out  1  rounding direction for the collision table
- busy  out  1  high in every state except IDLE
- last_wall  out  2  index of the most recently granted wall
- peak_impact  out  3  maximum impact_in captured since the last frame
- overflow  out  1  sticky flag: a hit arrived while its wall was already pending

## Operation
- Per wall there is a pending bit, a 2-bit stored phi and a done bit.
- Accepting a hit:
  - hit[i] with done[i]=0 sets pending[i] and stores its phi.
  - hit[i] with done[i]=1 is ignored.
  - hit[i] while pending[i]=1: the stored phi is overwritten and overflow is set. overflow clears only on rst.
- frame clears all done bits and sets peak_impact to 0. Pending bits are kept.
  - frame and hit[i] in the same cycle: the clear takes effect first, so the hit is accepted.
- FSM states:
  - IDLE: if any pending bit is set, grant the first pending wall at or after the round-robin pointer (wrapping 3 to 0). Register rotate, mirror and phi for that wall, clear its pending bit, set its done bit, load last_wall, advance the pointer to grant+1 mod 4, then go to SETUP.
  - SETUP: outputs are held stable and update=0. Next state is FIRE.
  - FIRE: update=1 and round_dir advances. Next state is SETTLE.
  - SETTLE: peak_impact <= max(peak_impact, impact_in). If frame is also high this cycle, peak_impact <= impact_in instead. Next state is IDLE.
- rotate, mirror, phi and round_dir hold their values outside a grant.
- A hit for the wall currently in flight goes through normal acceptance. Its done bit is already set, so the hit is ignored until the next frame.
- rst mid-sequence returns the FSM to IDLE immediately; update is never emitted after rst is asserted.

## Timing
- Reset values:
  - update, rotate, mirror, busy, overflow = 0
  - phi, last_wall, peak_impact = 0
  - round_dir = 0 in toggle mode, 1 in LFSR mode
  - round-robin pointer = 0; all pending and done bits = 0; FSM in IDLE
- Pipeline for a hit[i] pulse in cycle t, FSM idle:
  - t+1: pending is visible; the FSM is in IDLE and grants.
  - t+2: SETUP; the setup outputs are valid.
  - t+3: FIRE, update=1.
  - t+4: SETTLE; impact_in is valid and is captured at the end of this cycle.
  - t+5: IDLE; peak_impact is updated.
- Each grant takes 4 cycles. Back-to-back grants give an update every 4 cycles.
- busy is high from SETUP through SETTLE.

## Configuration
- ROUND_LFSR_EN defined:
  - round_dir = lfsr[0] of an 8-bit Fibonacci LFSR with taps x^8+x^6+x^5+x^4+1, seeded to 8'h01 at reset.
  - The LFSR advances once per FIRE.
- ROUND_LFSR_EN undefined:
  - round_dir is a toggle flop that resets to 0 and inverts once per FIRE.

## Test plan
- Single hit: hit=4'b0100 with hit_phi[5:4]=2'b10 at cycle 10 -> update high at cycle 13 only; rotate=0, mirror=1, phi=2'b10 stable over cycles 12–14; last_wall=2.
- Simultaneous hits: hit=4'b1111 at reset pointer 0 -> grants in order 0,1,2,3 with updates at cycles t+3, t+7, t+11, t+15; then busy=0.
- Lockout: hit top, then hit top again with no frame -> exactly one update. Pulse frame, then hit top -> a second update.
- Overflow and phi overwrite: while the FSM is busy, hit[3] with phi 1 and then hit[3] with phi 3 before it is granted -> overflow=1; the single grant drives phi=3.
- Peak impact: impact_in of 5 then 2 on consecutive grants -> peak_impact=5. frame during the next SETTLE with impact_in=1 -> peak_impact=1.
- Reset mid-sequence and round_dir: assert rst in SETUP -> no update, all outputs return to reset values. Four FIREs without the macro -> round_dir sequence 1,0,1,0. With the macro, round_dir matches a reference LFSR model.
